// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one 16-bit slice per stage; optional flags under PCLA_FLAGS_EN.
// Latency: WIDTH/16 cycles from accept to out_valid; one result per cycle when not stalled.
// Backpressure: stall = out_valid & ~out_ready freezes every stage; in_ready = ~stall.
module pipelined_cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int LAT = WIDTH / 16;

    // 16-bit adder built from four 4-bit groups with a lookahead carry across the groups.
    // Returns {carry_out, sum}.
    function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [15:0] p;
        logic [15:0] g;
        logic [3:0]  pg;
        logic [3:0]  gg;
        logic [4:0]  cg;
        logic [16:0] c;
        p = x ^ y;
        g = x & y;
        for (int j = 0; j < 4; j++) begin
            pg[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        cg[0] = ci;
        cg[1] = gg[0] | (pg[0] & ci);
        cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & ci);
        cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & ci);
        cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
              | (pg[3] & pg[2] & pg[1] & pg[0] & ci);
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c[4*j] = cg[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        c[16] = cg[4];
        return {c[16], p ^ c[15:0]};
    endfunction

    // Per-stage registers: operand skew (a_q/b_q), sum deskew (s_q), slice carry and valid.
    logic [WIDTH-1:0] a_q  [LAT];
    logic [WIDTH-1:0] b_q  [LAT];
    logic [WIDTH-1:0] s_q  [LAT];
    logic             c_q  [LAT];
    logic             v_q  [LAT];

    // Stage inputs (previous stage registers, or the ports for stage 0) and next-state values.
    logic [WIDTH-1:0] a_st [LAT];
    logic [WIDTH-1:0] b_st [LAT];
    logic [WIDTH-1:0] s_st [LAT];
    logic             c_st [LAT];
    logic             v_st [LAT];
    logic [16:0]      r    [LAT];
    logic [WIDTH-1:0] s_n  [LAT];
    logic             c_n  [LAT];

    logic stall;
    logic advance;

    assign out_valid = v_q[LAT-1] & ~rst;
    assign stall     = out_valid & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = ~stall;
    assign sum       = rst ? '0 : s_q[LAT-1];
    assign c_out     = c_q[LAT-1] & ~rst;

    // Route each stage's inputs: ports into stage 0 (B inverted for subtract), registers otherwise.
    always_comb begin
        a_st[0] = a;
        b_st[0] = sub ? ~b : b;
        c_st[0] = sub | c_in;
        s_st[0] = '0;
        v_st[0] = in_valid;
        for (int k = 1; k < LAT; k++) begin
            a_st[k] = a_q[k-1];
            b_st[k] = b_q[k-1];
            c_st[k] = c_q[k-1];
            s_st[k] = s_q[k-1];
            v_st[k] = v_q[k-1];
        end
    end

    // Each stage adds its own slice and merges it into the partial sum travelling with it.
    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            r[k]                = cla16(a_st[k][16*k +: 16], b_st[k][16*k +: 16], c_st[k]);
            s_n[k]              = s_st[k];
            s_n[k][16*k +: 16]  = r[k][15:0];
            c_n[k]              = r[k][16];
        end
    end

    // Pipeline registers: cleared on reset, frozen as a whole while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < LAT; k++) begin
                a_q[k] <= a_st[k];
                b_q[k] <= b_st[k];
                s_q[k] <= s_n[k];
                c_q[k] <= c_n[k];
                v_q[k] <= v_st[k];
            end
        end
    end

    // Already-consumed operand slices are dead after their stage; collected here so they are
    // visibly intentional, and synthesis trims them.
    logic unused_skew;
    always_comb begin
        unused_skew = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            unused_skew = unused_skew ^ (^a_q[k]) ^ (^b_q[k]);
        end
    end

`ifdef PCLA_FLAGS_EN
    logic ov_n;
    logic ov_q;
    logic zero_q;
    logic neg_q;

    // Overflow is carry into the MSB (recovered from the MSB sum bit) XOR carry out of the MSB.
    always_comb begin
        ov_n = (r[LAT-1][15] ^ a_st[LAT-1][WIDTH-1] ^ b_st[LAT-1][WIDTH-1]) ^ c_n[LAT-1];
    end

    // Flags registered alongside the final-stage sum so they stay aligned with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q   <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (advance) begin
            ov_q   <= ov_n;
            zero_q <= ~|s_n[LAT-1];
            neg_q  <= s_n[LAT-1][WIDTH-1];
        end
    end

    assign overflow = ov_q & ~rst;
    assign zero     = zero_q & ~rst;
    assign negative = neg_q & ~rst;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
    assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder at WIDTH=32 (two stages).
// Vector table for arithmetic, plus hand-written stall, bubble and reset sequences.
// Flag expectations collapse to 0 unless PCLA_FLAGS_EN is defined.
module tb_pipelined_cla_adder;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH / 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              c_in;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              c_out;
    logic              overflow;
    logic              zero;
    logic              negative;

    int checks   = 0;
    int failures = 0;

    pipelined_cla_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c_in;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs [10];

    function automatic logic flag_exp(input logic f);
`ifdef PCLA_FLAGS_EN
        return f;
`else
        return 1'b0 & f;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Enter at posedge+1; leave at posedge+1 after the result has drained.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        c_in      = v.c_in;
        sub       = v.sub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, LAT - 1);
        chk({tag, "_sum"},     sum,      v.s);
        chk({tag, "_cout"},    c_out,    v.co);
        chk({tag, "_ovf"},     overflow, flag_exp(v.ov));
        chk({tag, "_zero"},    zero,     flag_exp(v.z));
        chk({tag, "_neg"},     negative, flag_exp(v.n));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sa [4];
        logic [31:0] sb [4];
        logic        ssub [4];
        logic [31:0] sexp [4];
        logic [31:0] expq [$];
        logic [31:0] held;
        logic        was_stalled;
        logic        fire;
        int issued, got, hold, acc, seen, drained, stray;
        vec_t wrap;

        //              a             b             cin   sub   sum           co    ov    z     n
        vecs[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{32'h00010000, 32'h00000001, 1'b0, 1'b1, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 1'b0};

        sa[0] = 32'h0000FFFF; sb[0] = 32'h00000001; ssub[0] = 1'b0; sexp[0] = 32'h00010000;
        sa[1] = 32'h11111111; sb[1] = 32'h22222222; ssub[1] = 1'b0; sexp[1] = 32'h33333333;
        sa[2] = 32'hFFFF0000; sb[2] = 32'h00010000; ssub[2] = 1'b0; sexp[2] = 32'h00000000;
        sa[3] = 32'h00000010; sb[3] = 32'h00000001; ssub[3] = 1'b1; sexp[3] = 32'h0000000F;

        // Reset held with a live operand on the inputs.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 32'hDEADBEEF; b = 32'h12345678; c_in = 1'b1; sub = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum",       sum,       32'h0);
        chk("rst_cout",      c_out,     1'b0);
        chk("rst_ovf",       overflow,  1'b0);
        chk("rst_zero",      zero,      1'b0);
        chk("rst_neg",       negative,  1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;

        // Arithmetic table, one operation at a time.
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Four back-to-back ops with a three-cycle stall on the first result.
        issued = 0; got = 0; hold = 3; was_stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (out_valid && hold > 0) begin
                out_ready = 1'b0;
                hold--;
            end else begin
                out_ready = 1'b1;
            end
            if (issued < 4) begin
                in_valid = 1'b1; a = sa[issued]; b = sb[issued]; sub = ssub[issued]; c_in = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("stream_in_ready", in_ready, !(out_valid && !out_ready));
            if (was_stalled) chk("stream_hold", sum, held);
            if (out_valid) begin
                if (expq.size() > 0) chk($sformatf("stream_res%0d", got), sum, expq[0]);
                if (out_ready) begin
                    if (expq.size() > 0) void'(expq.pop_front());
                    got++;
                end
            end
            was_stalled = out_valid && !out_ready;
            held = sum;
            fire = in_valid && in_ready;
            if (fire) begin
                expq.push_back(sexp[issued]);
                issued++;
            end
            @(posedge clk); #1;
        end
        chk("stream_issued", issued, 4);
        chk("stream_count",  got,    4);
        chk("stream_left",   expq.size(), 0);

        // Alternating valid with the consumer blocked: bubbles collapse until the output fills.
        in_valid = 1'b0; out_ready = 1'b0; acc = 0; seen = 0;
        a = 32'h00000100; b = 32'h00000023; sub = 1'b0; c_in = 1'b0;
        for (int cyc = 0; cyc < 8 && seen == 0; cyc++) begin
            in_valid = (cyc % 2 == 0);
            #1;
            if (out_valid) begin
                seen = 1;
            end else begin
                if (in_valid && in_ready) acc++;
                @(posedge clk); #1;
            end
        end
        chk("bubble_filled",   seen,      1);
        chk("bubble_in_ready", in_ready,  1'b0);
        chk("bubble_sum",      sum,       32'h00000123);
        for (int cyc = 0; cyc < 2; cyc++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bubble_hold_valid", out_valid, 1'b1);
            chk("bubble_hold_ready", in_ready,  1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1; drained = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            #1;
            if (out_valid) drained++;
            @(posedge clk); #1;
        end
        chk("bubble_drained", drained, acc);

        // Two ops in flight, then a one-cycle reset: nothing may emerge afterwards.
        out_ready = 1'b1; in_valid = 1'b1; sub = 1'b0; c_in = 1'b0;
        a = 32'h00000001; b = 32'h00000002;
        @(posedge clk); #1;
        a = 32'h00000003; b = 32'h00000004;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("midrst_valid_during", out_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; stray = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (out_valid) stray++;
            @(posedge clk); #1;
        end
        chk("midrst_stray", stray, 0);
        wrap = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0};
        run_vec(wrap, "midrst_new");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor for datapath widths above 16 bits. The operand is cut into 16-bit slices. Each slice is added by a 4×4-bit lookahead slice, and a pipeline register sits between slices, so throughput is one operation per cycle at a clock rate set by a single 16-bit slice. It sits between the register-read stage and the ALU result mux, and carries a valid/ready handshake so downstream stalls propagate upstream.

## Interface
Parameters:
- `WIDTH`, 32: operand width; must be a multiple of 16, range 16..128.
- `LAT` (localparam), `WIDTH/16`: pipeline depth in cycles.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operands present.
- `in_ready` out 1: pipe accepts this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `c_in` in 1: carry-in; ignored when `sub`=1.
- `sub` in 1: 0 = A+B+c_in; 1 = A+~B+1.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer takes result.
- `sum` out WIDTH: result.
- `c_out` out 1: carry out of the MSB; for subtraction, 1 = no borrow.
- `overflow` out 1: two's-complement overflow.
- `zero` out 1: `sum`==0.
- `negative` out 1: `sum[WIDTH-1]`.

## Operation
- Stage k (k = 0..LAT-1) adds slice k (bits 16k+15..16k) using the carry registered by stage k-1. Stage 0 uses `sub ? 1 : c_in`. B is inverted at entry when `sub`=1.
- Unprocessed upper operand slices travel forward in skew registers. Completed lower sum slices travel forward in deskew registers, so all slices of one operation emerge together.
- Every stage holds a valid bit. The valid bit and data advance only when the pipe is not stalled.
- Stall: `stall = out_valid & ~out_ready`. While stalled, every stage register holds its value, including bubbles.
- `in_ready = ~stall`, combinational. An operation is accepted when `in_valid & in_ready`. A bubble (valid=0) enters when `in_valid`=0 and the pipe is not stalled.
- `out_valid`, `sum` and `c_out` come from the final stage registers; there is no combinational path from `a`/`b` to `sum`.
- `overflow` is the carry into the MSB XOR the carry out of the MSB. It is computed in the last stage and registered with `sum`.
- Results leave in acceptance order. There is no reordering and no dropping.
- `WIDTH`=16 gives LAT=1: a single registered stage.

## Timing
- Reset: all valid bits 0, and all data/carry/skew registers 0. While `rst` is high, `out_valid`=0, `sum`=0, `c_out`=0, `overflow`=0, `zero`=0, `negative`=0, and `in_ready`=1.
- Reset mid-operation: all in-flight operations are discarded. Nothing emerges after `rst` deasserts.
- An operation accepted on edge T appears with `out_valid`=1 after edge T+LAT−1 (visible in cycle T+LAT), provided no stall occurs in between.
- Each stall cycle adds exactly one cycle of latency.
- Throughput: one result per cycle while `out_ready`=1.
- Same-cycle accept and drain is allowed:
  - With `out_valid`=1 and `out_ready`=1, a new operand is accepted in the same cycle.
  - With `out_valid`=0, the pipe advances even when `out_ready`=0, so bubbles collapse.
- Outputs hold stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `PCLA_FLAGS_EN` defined:
  - `zero`, `negative` and `overflow` are computed and registered as above.
  - `zero` is a WIDTH-bit NOR of the final sum, registered with the final stage.
- `PCLA_FLAGS_EN` undefined:
  - Flag logic and its registers are omitted.
  - `zero`, `negative` and `overflow` are tied to 0.
  - `sum` and `c_out` behave identically in both builds.

## Test plan
All scenarios use WIDTH=32, LAT=2.
- Reset: hold `rst` with `in_valid`=1 → `out_valid`=0, all outputs 0, `in_ready`=1. After release, the first accepted op emerges exactly 2 cycles later.
- Cross-slice carry: a=0x0000FFFF, b=0x00000001, sub=0, c_in=0 → sum=0x00010000, c_out=0, zero=0.
- Subtract and overflow: a=0x80000000, b=0x00000001, sub=1 → sum=0x7FFFFFFF, c_out=1, overflow=1, negative=0. Then a=5, b=5, sub=1 → sum=0, zero=1, c_out=1.
- Back-to-back with a stall: issue 4 ops in consecutive cycles with `out_ready` low for 3 cycles after the first `out_valid`:
  - `in_ready` drops in the same cycle as the stall.
  - Results are held stable.
  - All 4 results emerge in order.
  - None is lost or duplicated.
- Bubbles: alternate `in_valid` 1/0 with `out_ready`=0 → the pipe fills until `out_valid`=1, and then `in_ready`=0.
- Mid-flight reset: accept 2 ops, assert `rst` for one cycle → no `out_valid` until a new op is issued. The new op's result is correct: a=0xFFFFFFFF, b=1, c_in=1 → sum=0x00000001, c_out=1.
